// File: rtl/match_event_logger.sv
// ---------------------------------------------------------------------------
// match_event_logger
//
// Purpose:
//   Sits behind the serial pattern detector. It turns each rising edge of the
//   detector's registered match level into a timestamped event and queues it
//   in a small show-ahead FIFO. A consumer drains the FIFO with a valid/ready
//   handshake. The block also keeps a saturating count of all detected
//   matches and a sticky flag raised when an event had to be dropped because
//   the FIFO was full.
//
// Parameters:
//   TS_W   width of the free-running timestamp counter and of evt_ts
//   DEPTH  FIFO entries (power of two, at least 2)
//   CNT_W  width of the saturating match counter
//
// Ports:
//   clk          single clock, all state on the rising edge
//   rst_n        asynchronous active-low reset
//   match_in     detector match level
//   clr          synchronous clear of FIFO, match count and overflow flag
//   evt_valid    FIFO non-empty, head entry presented on evt_ts
//   evt_ready    consumer accepts the head entry
//   evt_ts       head entry (holds its last value while the FIFO is empty)
//   fifo_level   number of entries held
//   match_count  detected matches, saturating at 2^CNT_W-1
//   overflow     sticky: an event was dropped because the FIFO was full
//
// Build option:
//   LOG_DELTA_EN  when defined, each entry stores the number of cycles since
//                 the previous detected event (saturating at 2^TS_W-1)
//                 instead of the absolute timestamp.
// ---------------------------------------------------------------------------
module match_event_logger #(
    parameter int TS_W  = 16,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     match_in,
    input  logic                     clr,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [TS_W-1:0]          evt_ts,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]         match_count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [AW:0]   PTR_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] IDX_ONE = AW'(1);

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [TS_W-1:0] ts_cnt;
    logic            match_d;
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic [TS_W-1:0] mem [DEPTH];
    logic [TS_W-1:0] head_q;
    logic [CNT_W-1:0] cnt_q;
    logic            ovf_q;

    // -----------------------------------------------------------------------
    // Combinational control
    // -----------------------------------------------------------------------
    logic            event_det;
    logic            empty;
    logic            full;
    logic            do_pop;
    logic            do_push;
    logic            do_drop;
    logic [TS_W-1:0] wdata;
    logic [TS_W-1:0] head_next;
    logic [AW-1:0]   rd_idx_nxt;

    // Rising edge of the match level; a held level yields one event only.
    assign event_det = match_in & ~match_d;

    // The wrap bit separates full (same index, different lap) from empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // clr overrides both a pop and a push on the same edge.
    assign do_pop  = ~empty & evt_ready & ~clr;
    assign do_push = event_det & ~clr & (~full | do_pop);
    assign do_drop = event_det & ~clr & full & ~do_pop;

    assign rd_idx_nxt = rd_ptr[AW-1:0] + IDX_ONE;

`ifdef LOG_DELTA_EN
    // Cycles since the previous detected event (accepted or dropped).
    function automatic logic [TS_W-1:0] gap_sat_inc(input logic [TS_W-1:0] v);
        return (&v) ? v : v + TS_W'(1);
    endfunction

    logic [TS_W-1:0] gap_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt <= '0;
        end else if (clr) begin
            gap_cnt <= '0;
        end else if (event_det) begin
            gap_cnt <= TS_W'(1);
        end else begin
            gap_cnt <= gap_sat_inc(gap_cnt);
        end
    end

    assign wdata = gap_cnt;
`else
    assign wdata = ts_cnt;
`endif

    // Value the head register must show after this edge. Tracking the head in
    // a register (rather than reading mem at rd_ptr) lets it hold the last
    // presented entry once the FIFO drains and gives a clean reset value.
    always_comb begin
        head_next = head_q;
        if (!clr) begin
            if (do_pop) begin
                if (fifo_level > LW'(1)) begin
                    head_next = mem[rd_idx_nxt];
                end else if (do_push) begin
                    head_next = wdata;
                end
            end else if (empty && do_push) begin
                head_next = wdata;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Timestamp and edge-detect registers (unaffected by clr)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_cnt  <= '0;
            match_d <= 1'b0;
        end else begin
            ts_cnt  <= ts_cnt + TS_W'(1);
            match_d <= match_in;
        end
    end

    // -----------------------------------------------------------------------
    // FIFO pointers and head register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            head_q <= '0;
        end else begin
            head_q <= head_next;
            if (clr) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
            end
        end
    end

    // FIFO storage is pure data and needs no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    // -----------------------------------------------------------------------
    // Match counter and sticky overflow
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (clr) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            // Dropped events are still counted.
            if (event_det) begin
                cnt_q <= cnt_sat_inc(cnt_q);
            end
            if (do_drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign evt_valid   = ~empty;
    assign evt_ts      = head_q;
    assign fifo_level  = wr_ptr - rd_ptr;
    assign match_count = cnt_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_match_event_logger.sv
// ---------------------------------------------------------------------------
// tb_match_event_logger
//
// Self-checking bench for match_event_logger (TS_W=8, DEPTH=4, CNT_W=3).
// A queue-based model of the logger is stepped on every rising edge and
// compared with the DUT outputs on every falling edge. Directed scenarios
// pin the model with hand-computed values, then randomized traffic runs.
// ---------------------------------------------------------------------------
module tb_match_event_logger;

    localparam int TS_W    = 8;
    localparam int DEPTH   = 4;
    localparam int CNT_W   = 3;
    localparam int LW      = $clog2(DEPTH) + 1;
    localparam int TS_MAX  = (1 << TS_W) - 1;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              match_in = 1'b0;
    logic              clr = 1'b0;
    logic              evt_ready = 1'b0;
    logic              evt_valid;
    logic [TS_W-1:0]   evt_ts;
    logic [LW-1:0]     fifo_level;
    logic [CNT_W-1:0]  match_count;
    logic              overflow;

    int checks = 0;
    int errors = 0;

    // model state
    int mq[$];
    int m_ts   = 0;
    int m_gap  = 0;
    int m_cnt  = 0;
    int m_head = 0;
    bit m_prev = 1'b0;
    bit m_ovf  = 1'b0;

    match_event_logger #(
        .TS_W (TS_W),
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .match_in   (match_in),
        .clr        (clr),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_ts     (evt_ts),
        .fifo_level (fifo_level),
        .match_count(match_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ts   = 0;
        m_gap  = 0;
        m_cnt  = 0;
        m_head = 0;
        m_prev = 1'b0;
        m_ovf  = 1'b0;
    endtask

    // One clock edge worth of behaviour, from the logger's rules.
    task automatic model_step();
        bit ev;
        int val;
        ev = match_in && !m_prev;
        m_prev = match_in;
`ifdef LOG_DELTA_EN
        val = m_gap;
`else
        val = m_ts;
`endif
        if (clr) begin
            mq.delete();
            m_cnt = 0;
            m_ovf = 1'b0;
            m_gap = 0;
        end else begin
            if (mq.size() != 0 && evt_ready) void'(mq.pop_front());
            if (ev) begin
                if (mq.size() < DEPTH) mq.push_back(val);
                else m_ovf = 1'b1;
                if (m_cnt < CNT_MAX) m_cnt++;
                m_gap = 1;
            end else if (m_gap < TS_MAX) begin
                m_gap++;
            end
            if (mq.size() != 0) m_head = mq[0];
        end
        m_ts = (m_ts + 1) % (TS_MAX + 1);
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Compare process: DUT outputs against the model away from the edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("evt_valid", 32'(evt_valid), (mq.size() != 0) ? 1 : 0);
            chk("fifo_level", 32'(fifo_level), mq.size());
            chk("evt_ts", 32'(evt_ts), m_head);
            chk("match_count", 32'(match_count), m_cnt);
            chk("overflow", 32'(overflow), m_ovf ? 1 : 0);
        end
    end

    // Apply inputs for the next edge, return at the falling edge after it.
    task automatic cyc(input bit m, input bit r, input bit c);
        match_in  = m;
        evt_ready = r;
        clr       = c;
        @(negedge clk);
    endtask

    // Called at a falling edge; returns at a falling edge with rst_n freshly
    // released, so the next cyc() is edge 1 (pre-increment timestamp 0).
    task automatic do_reset();
        #2;
        rst_n     = 1'b0;
        match_in  = 1'b0;
        evt_ready = 1'b0;
        clr       = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int exp_ovf[4];
    int exp_pp[4];

    initial begin
`ifdef LOG_DELTA_EN
        exp_ovf = '{10, 2, 2, 2};
        exp_pp  = '{2, 2, 2, 4};
`else
        exp_ovf = '{10, 12, 14, 16};
        exp_pp  = '{12, 14, 16, 20};
`endif
        // reset state
        do_reset();
        chk("rst_valid", 32'(evt_valid), 0);
        chk("rst_ts", 32'(evt_ts), 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_count", 32'(match_count), 0);
        chk("rst_ovf", 32'(overflow), 0);

        // reset mid-operation with two entries queued
        cyc(0, 0, 0); cyc(1, 0, 0); cyc(0, 0, 0); cyc(1, 0, 0); cyc(0, 0, 0);
        chk("mid_level_pre", 32'(fifo_level), 2);
        chk("mid_ts_pre", 32'(evt_ts), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_valid", 32'(evt_valid), 0);
        chk("mid_level", 32'(fifo_level), 0);
        chk("mid_count", 32'(match_count), 0);
        chk("mid_ovf", 32'(overflow), 0);
        chk("mid_ts", 32'(evt_ts), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // single pulse at edge 5
        do_reset();
        repeat (4) cyc(0, 0, 0);
        cyc(1, 0, 0);
        chk("pulse_valid", 32'(evt_valid), 1);
        chk("pulse_ts", 32'(evt_ts), 4);
        chk("pulse_level", 32'(fifo_level), 1);
        chk("pulse_count", 32'(match_count), 1);
        cyc(0, 1, 0);
        chk("pulse_pop_valid", 32'(evt_valid), 0);
        chk("pulse_hold_ts", 32'(evt_ts), 4);

        // held level over edges 3..5
        do_reset();
        cyc(0, 0, 0); cyc(0, 0, 0);
        cyc(1, 0, 0); cyc(1, 0, 0); cyc(1, 0, 0);
        cyc(0, 0, 0);
        chk("held_level", 32'(fifo_level), 1);
        chk("held_ts", 32'(evt_ts), 2);
        chk("held_count", 32'(match_count), 1);

        // overflow: pulses at ts 10,12,14,16,18 with no consumer
        do_reset();
        for (int k = 1; k <= 20; k++)
            cyc((k >= 11 && k <= 19 && (k % 2) == 1), 0, 0);
        chk("ovf_level", 32'(fifo_level), 4);
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_count", 32'(match_count), 5);
        for (int i = 0; i < 4; i++) begin
            chk("ovf_drain", 32'(evt_ts), exp_ovf[i]);
            cyc(0, 1, 0);
        end
        chk("ovf_drained", 32'(evt_valid), 0);
        chk("ovf_sticky", 32'(overflow), 1);

        // full with simultaneous pop and push at ts 20
        do_reset();
        for (int k = 1; k <= 20; k++)
            cyc((k >= 11 && k <= 17 && (k % 2) == 1), 0, 0);
        chk("pp_full", 32'(fifo_level), 4);
        cyc(1, 1, 0);
        chk("pp_level", 32'(fifo_level), 4);
        chk("pp_ovf", 32'(overflow), 0);
        for (int i = 0; i < 4; i++) begin
            chk("pp_drain", 32'(evt_ts), exp_pp[i]);
            cyc(0, 1, 0);
        end
        chk("pp_drained", 32'(fifo_level), 0);

        // saturation, then clr coincident with a pulse
        do_reset();
        repeat (9) begin
            cyc(1, 0, 0);
            cyc(0, 0, 0);
        end
        chk("sat_count", 32'(match_count), 7);
        chk("sat_ovf", 32'(overflow), 1);
        cyc(1, 0, 1);
        chk("clr_count", 32'(match_count), 0);
        chk("clr_level", 32'(fifo_level), 0);
        chk("clr_ovf", 32'(overflow), 0);
        cyc(0, 0, 0);
        chk("clr_nolog", 32'(fifo_level), 0);
        cyc(1, 0, 0);
        cyc(1, 0, 1);
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        chk("clr_held", 32'(match_count), 0);

        // pulses at ts 3 and 8
        do_reset();
        for (int k = 1; k <= 10; k++)
            cyc((k == 4 || k == 9), 0, 0);
        chk("two_first", 32'(evt_ts), 3);
        cyc(0, 1, 0);
`ifdef LOG_DELTA_EN
        chk("two_second", 32'(evt_ts), 5);
`else
        chk("two_second", 32'(evt_ts), 8);
`endif

        // randomized traffic
        for (int blk = 0; blk < 12; blk++) begin
            int pm;
            int pr;
            pm = $urandom_range(1, 4);
            pr = $urandom_range(0, 4);
            for (int n = 0; n < 250; n++)
                cyc(($urandom_range(0, pm) == 0), ($urandom_range(0, 4) < pr),
                    ($urandom_range(0, 63) == 0));
            if (blk == 5) do_reset();
        end

        // long quiet stretch (gap saturation, timestamp wrap), then pulses
        repeat (DEPTH + 2) cyc(0, 1, 0);
        repeat (300) cyc(0, 0, 0);
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        cyc(1, 0, 0);
        repeat (4) cyc(0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
